// File: rtl/matrix_window_ctrl.sv
// Timing/control for a 3x3 sliding window fed by two line-shift RAMs: tracks
// frame/line position, qualifies complete windows, flags image borders and framing errors.
module matrix_window_ctrl #(
  parameter logic [10:0] IMG_HDISP = 11'd640,
  parameter logic [10:0] IMG_VDISP = 11'd480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  output logic        line_shift_ce,
  output logic        win_valid,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic        border_l,
  output logic        border_r,
  output logic        border_t,
  output logic        border_b,
  output logic        frame_start,
  output logic        frame_done,
  output logic        err_line,
  output logic        err_frame,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  localparam logic [10:0] CNT_MAX = 11'h7FF;

  state_t      state_q, state_d;
  logic        vsync_q, href_q;
  logic [10:0] col_q, col_d, row_q, row_d;
  logic [10:0] px_q, px_d, py_q, py_d;
  logic        wv_q, wv_d;
  logic        bl_q, bl_d, br_q, br_d, bt_q, bt_d, bb_q, bb_d;
  logic        fs_q, fs_d, fd_q, fd_d, el_q, el_d, ef_q, ef_d;
  logic        vs_rise, h_fall, active, ef_set;

  assign vs_rise = per_frame_vsync & ~vsync_q;
  assign h_fall  = ~per_frame_href & href_q;
  assign active  = (state_q == FILL) || (state_q == RUN);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    // vs_rise overrides any line end in the same cycle: no row advance, no line check
    if (vs_rise) begin
      state_d = FILL;
      col_d   = '0;
      row_d   = '0;
    end else if (active) begin
      if (per_frame_href && col_q != CNT_MAX) col_d = col_q + 11'd1;
      if (h_fall) begin
        col_d = '0;
        if (row_q != CNT_MAX) row_d = row_q + 11'd1;
        if (state_q == FILL && row_q == 11'd1)                  state_d = RUN;
        if (state_q == RUN  && row_q == IMG_VDISP - 11'd1)      state_d = DONE;
      end
    end
  end

  always_comb begin
    wv_d = per_frame_href && (state_q == RUN) && (col_q >= 11'd2);
    px_d = wv_d ? col_q : '0;
    py_d = wv_d ? row_q : '0;
    bl_d = wv_d && (col_q == 11'd2);
    br_d = wv_d && (col_q == IMG_HDISP - 11'd1);
    bt_d = wv_d && (row_q == 11'd2);
    bb_d = wv_d && (row_q == IMG_VDISP - 11'd1);
    fs_d = vs_rise;
    fd_d = (state_d == DONE) && (state_q != DONE);
    el_d = el_q;
    if (vs_rise)                                   el_d = 1'b0;
    else if (active && h_fall && col_q != IMG_HDISP) el_d = 1'b1;
    ef_set = (vs_rise && active) || (per_frame_href && state_q == DONE);
    ef_d   = ef_set ? 1'b1 : (vs_rise ? 1'b0 : ef_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
      wv_q    <= 1'b0;
      bl_q    <= 1'b0;
      br_q    <= 1'b0;
      bt_q    <= 1'b0;
      bb_q    <= 1'b0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
      el_q    <= 1'b0;
      ef_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= per_frame_vsync;
      href_q  <= per_frame_href;
      col_q   <= col_d;
      row_q   <= row_d;
      px_q    <= px_d;
      py_q    <= py_d;
      wv_q    <= wv_d;
      bl_q    <= bl_d;
      br_q    <= br_d;
      bt_q    <= bt_d;
      bb_q    <= bb_d;
      fs_q    <= fs_d;
      fd_q    <= fd_d;
      el_q    <= el_d;
      ef_q    <= ef_d;
    end
  end

  assign line_shift_ce = ~rst & per_frame_href & active;
  assign win_valid     = wv_q;
  assign pix_x         = px_q;
  assign pix_y         = py_q;
  assign border_l      = bl_q;
  assign border_r      = br_q;
  assign border_t      = bt_q;
  assign border_b      = bb_q;
  assign frame_start   = fs_q;
  assign frame_done    = fd_q;
  assign err_line      = el_q;
  assign err_frame     = ef_q;
  assign state         = state_q;

endmodule

// File: tb/tb_matrix_window_ctrl.sv
// Bench for matrix_window_ctrl on an 8x6 image: directed frame table, border/reset
// sequences, and random frames checked cycle by cycle against a frame-position model.
module tb_matrix_window_ctrl;

  localparam logic [10:0] HD = 11'd8;
  localparam logic [10:0] VD = 11'd6;

  logic        clk = 1'b0;
  logic        rst, vs, hr;
  logic        line_shift_ce, win_valid;
  logic [10:0] pix_x, pix_y;
  logic        border_l, border_r, border_t, border_b;
  logic        frame_start, frame_done, err_line, err_frame;
  logic [1:0]  state;

  matrix_window_ctrl #(.IMG_HDISP(HD), .IMG_VDISP(VD)) dut (
    .clk(clk), .rst(rst), .per_frame_vsync(vs), .per_frame_href(hr),
    .line_shift_ce(line_shift_ce), .win_valid(win_valid), .pix_x(pix_x), .pix_y(pix_y),
    .border_l(border_l), .border_r(border_r), .border_t(border_t), .border_b(border_b),
    .frame_start(frame_start), .frame_done(frame_done), .err_line(err_line),
    .err_frame(err_frame), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wv;
    logic [10:0] px, py;
    logic        bl, br, bt, bb, fs, fd, el, ef;
    logic [1:0]  st;
  } out_t;

  typedef struct {
    int short_row; int len; int trunc_row; int ovr;
    int fs; int wv; int fd; int ce;
    logic el; logic ef; logic [1:0] st;
  } scen_t;

  int n_chk = 0, n_pass = 0;
  int cnt_fs, cnt_wv, cnt_fd, cnt_ce;
  bit got_first;
  logic [25:0] first_rec, last_rec;

  // model: phase 0 = no frame, 1 = receiving frame, 2 = frame complete
  int   m_phase = 0, m_x = 0, m_y = 0;
  bit   m_pvs = 0, m_phr = 0, m_el = 0, m_ef = 0;
  out_t exp_o = '0;

  function automatic logic [32:0] act_v();
    return {win_valid, pix_x, pix_y, border_l, border_r, border_t, border_b,
            frame_start, frame_done, err_line, err_frame, state};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic model_step(input bit v, input bit h, input bit r);
    bit rise, fall, infr;
    if (r) begin
      exp_o = '0; m_phase = 0; m_x = 0; m_y = 0;
      m_pvs = 0; m_phr = 0; m_el = 0; m_ef = 0;
      return;
    end
    rise = v && !m_pvs;
    fall = !h && m_phr;
    infr = (m_phase == 1);
    exp_o = '0;
    exp_o.wv = h && infr && m_y >= 2 && m_x >= 2;
    if (exp_o.wv) begin
      exp_o.px = 11'(m_x);
      exp_o.py = 11'(m_y);
      exp_o.bl = (m_x == 2);
      exp_o.br = (m_x == int'(HD) - 1);
      exp_o.bt = (m_y == 2);
      exp_o.bb = (m_y == int'(VD) - 1);
    end
    exp_o.fs = rise;
    exp_o.fd = fall && infr && m_y == int'(VD) - 1 && !rise;
    if ((rise && infr) || (h && m_phase == 2)) m_ef = 1;
    else if (rise)                             m_ef = 0;
    if (rise)                                  m_el = 0;
    else if (fall && infr && m_x != int'(HD))  m_el = 1;
    if (rise) begin
      m_phase = 1; m_x = 0; m_y = 0;
    end else if (infr) begin
      if (h) m_x = (m_x < 2047) ? m_x + 1 : 2047;
      if (fall) begin
        if (m_y == int'(VD) - 1) m_phase = 2;
        m_x = 0;
        m_y = (m_y < 2047) ? m_y + 1 : 2047;
      end
    end
    exp_o.el = m_el;
    exp_o.ef = m_ef;
    exp_o.st = (m_phase == 0) ? 2'd0 : (m_phase == 2) ? 2'd3 : (m_y < 2) ? 2'd1 : 2'd2;
    m_pvs = v;
    m_phr = h;
  endtask

  task automatic cyc(input logic v, input logic h);
    logic exp_ce;
    vs = v; hr = h;
    #1;
    exp_ce = h && (m_phase == 1) && !rst;
    check("line_shift_ce", 64'(line_shift_ce), 64'(exp_ce));
    cnt_ce += int'(line_shift_ce);
    @(posedge clk);
    model_step(v, h, rst);
    #1;
    check("outputs", 64'(act_v()), 64'(exp_o));
    cnt_fs += int'(frame_start);
    cnt_wv += int'(win_valid);
    cnt_fd += int'(frame_done);
    if (win_valid) begin
      if (!got_first) first_rec = {pix_x, pix_y, border_l, border_r, border_t, border_b};
      got_first = 1;
      last_rec = {pix_x, pix_y, border_l, border_r, border_t, border_b};
    end
  endtask

  task automatic drive_line(input int len, input int gap);
    for (int i = 0; i < len; i++) cyc(1'b0, 1'b1);
    for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0);
  endtask

  scen_t tbl[5];

  initial begin
    //            short len trunc ovr  fs  wv fd  ce  el    ef    st
    tbl[0] = '{-1, 8, -1, 0, 1, 24, 1, 48, 1'b0, 1'b0, 2'd3};
    tbl[1] = '{ 3, 7, -1, 0, 1, 23, 1, 47, 1'b1, 1'b0, 2'd3};
    tbl[2] = '{-1, 8, -1, 4, 1, 24, 1, 48, 1'b0, 1'b1, 2'd3};
    tbl[3] = '{ 4, 9, -1, 0, 1, 25, 1, 49, 1'b1, 1'b0, 2'd3};
    tbl[4] = '{-1, 8,  3, 0, 2, 12, 0, 32, 1'b0, 1'b1, 2'd1};
    cnt_fs = 0; cnt_wv = 0; cnt_fd = 0; cnt_ce = 0; got_first = 0;
    first_rec = '0; last_rec = '0;

    rst = 1'b1; vs = 1'b0; hr = 1'b0;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    check("reset_state", 64'(act_v()), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);

    for (int s = 0; s < 5; s++) begin
      cnt_fs = 0; cnt_wv = 0; cnt_fd = 0; cnt_ce = 0; got_first = 0;
      cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
      for (int r = 0; r < 6; r++) begin
        drive_line((r == tbl[s].short_row) ? tbl[s].len : 8, 2);
        if (r == tbl[s].trunc_row) begin
          cyc(1'b1, 1'b0);
          check("trunc_restart", 64'({err_frame, frame_start, state, pix_x, pix_y, win_valid}),
                64'({1'b1, 1'b1, 2'd1, 23'd0}));
          cyc(1'b0, 1'b0);
          break;
        end
      end
      for (int i = 0; i < tbl[s].ovr; i++) cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
      check($sformatf("s%0d_frame_start_cnt", s), 64'(cnt_fs), 64'(tbl[s].fs));
      check($sformatf("s%0d_win_valid_cnt", s), 64'(cnt_wv), 64'(tbl[s].wv));
      check($sformatf("s%0d_frame_done_cnt", s), 64'(cnt_fd), 64'(tbl[s].fd));
      check($sformatf("s%0d_shift_ce_cnt", s), 64'(cnt_ce), 64'(tbl[s].ce));
      check($sformatf("s%0d_flags_state", s), 64'({err_line, err_frame, state}),
            64'({tbl[s].el, tbl[s].ef, tbl[s].st}));
      if (s == 0) begin
        check("border_first", 64'(first_rec), 64'({11'd2, 11'd2, 1'b1, 1'b0, 1'b1, 1'b0}));
        check("border_last",  64'(last_rec),  64'({11'd7, 11'd5, 1'b0, 1'b1, 1'b0, 1'b1}));
      end
    end

    // reset in the middle of row 3 (RUN), then href without a new vsync edge
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
    for (int r = 0; r < 3; r++) drive_line(8, 2);
    drive_line(4, 0);
    rst = 1'b1;
    cyc(1'b0, 1'b1);
    rst = 1'b0;
    check("rst_mid_run_outs", 64'(act_v()), 64'd0);
    cnt_ce = 0;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    check("rst_idle_shift_ce", 64'(cnt_ce), 64'd0);
    check("rst_idle_state", 64'({state, err_frame, frame_done}), 64'd0);

    // random frames: odd line lengths, early vsync, overruns, rare resets
    for (int f = 0; f < 30; f++) begin
      int hold, nrows, len;
      hold = int'($urandom_range(1, 3));
      for (int i = 0; i < hold; i++) cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      nrows = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 5)) : 6;
      for (int r = 0; r < nrows; r++) begin
        len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(5, 10)) : 8;
        for (int i = 0; i < len; i++) begin
          rst = ($urandom_range(0, 199) == 0);
          cyc(1'b0, 1'b1);
          rst = 1'b0;
        end
        drive_line(0, int'($urandom_range(1, 3)));
      end
      if ($urandom_range(0, 3) == 0) drive_line(int'($urandom_range(1, 3)), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/matrix_window_ctrl.md
MATRIX_WINDOW_CTRL -- requirements
Module: matrix_window_ctrl

Interface
REQ-001 Parameter IMG_HDISP, 11'd640, active pixels per line.
REQ-002 Parameter IMG_VDISP, 11'd480, active lines per frame.
REQ-003 clk  input  1  pixel clock; every register is clocked on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 per_frame_vsync  input  1  frame sync; a rising edge starts a frame.
REQ-006 per_frame_href  input  1  line valid; high for one cycle per pixel.
REQ-007 line_shift_ce  output  1  clock enable for both line-shift RAMs and the row-3 register; combinational.
REQ-008 win_valid  output  1  the 3x3 window is fully populated for the current pixel; registered.
REQ-009 pix_x  output  11  column of the pixel that produced this output cycle; registered.
REQ-010 pix_y  output  11  row of that pixel; registered.
REQ-011 border_l, border_r, border_t, border_b  output  1 each  window touches the left, right, top or bottom image edge; registered.
REQ-012 frame_start  output  1  one-cycle pulse when a frame starts.
REQ-013 frame_done  output  1  one-cycle pulse when a frame completes.
REQ-014 err_line  output  1  sticky flag: a line length differed from IMG_HDISP.
REQ-015 err_frame  output  1  sticky flag: the frame was truncated, or an overrun occurred.
REQ-016 state  output  2  FSM state: IDLE=0, FILL=1, RUN=2, DONE=3.

Function
REQ-017 Edge detection uses vsync_d and href_d, each one cycle of delay. vs_rise = vsync & ~vsync_d. h_fall = ~href & href_d.
REQ-018 FSM transitions:
- Any state goes to FILL on vs_rise.
- FILL goes to RUN on the h_fall that ends row 1.
- RUN goes to DONE on the h_fall that ends row IMG_VDISP-1.
- DONE goes to FILL only on vs_rise.
- IDLE is left only on vs_rise.
REQ-019 On vs_rise, the following happen in the next cycle:
- frame_start=1.
- col_cnt=0 and row_cnt=0.
- err_line is cleared.
- err_frame is cleared, unless the same vs_rise sets it (REQ-027). Set wins over clear.
REQ-020 col_cnt increments on every href cycle and saturates at 2047. On h_fall, col_cnt is cleared and row_cnt increments, saturating at 2047.
REQ-021 line_shift_ce = per_frame_href & (state==FILL | state==RUN). In IDLE and DONE it is 0.
REQ-022 Latency is 1 cycle. When href is high at cycle t in FILL or RUN, at t+1:
- pix_x = col_cnt(t) and pix_y = row_cnt(t).
- win_valid = (state==RUN) & (col_cnt(t)>=2).
REQ-023 When win_valid=0, pix_x, pix_y and all border flags hold 0 at t+1.
REQ-024 Border flags are qualified by win_valid:
- border_l when pix_x==2.
- border_r when pix_x==IMG_HDISP-1.
- border_t when pix_y==2.
- border_b when pix_y==IMG_VDISP-1.
REQ-025 On h_fall, if the col_cnt value latched before clearing is not IMG_HDISP, err_line is set in the next cycle. The row still advances.
REQ-026 frame_done pulses for one cycle on the FILL/RUN-to-DONE transition cycle+1. It never pulses again until a new frame.
REQ-027 err_frame is set in either case:
- vs_rise occurs while state is FILL or RUN.
- href is high while state is DONE.
In DONE, href has no other effect.
REQ-028 A simultaneous h_fall and vs_rise is handled as follows:
- vs_rise has priority.
- The counters clear and no row increment occurs.
- err_line is not set from that line.
REQ-029 vsync level otherwise has no effect; only its rising edge matters.

Reset
REQ-030 While rst=1, at the next clock edge:
- state=IDLE.
- All counters, vsync_d, href_d, pix_x, pix_y, win_valid, border flags, frame_start, frame_done, err_line and err_frame become 0.
REQ-031 line_shift_ce is 0 throughout reset.
REQ-032 Reset asserted mid-frame aborts the frame. No frame_done or error flag results.
REQ-033 After reset is released, the block waits in IDLE for vs_rise. href is ignored and line_shift_ce stays 0 until then.

Verification (IMG_HDISP=8, IMG_VDISP=6)
REQ-034 Nominal frame: vs_rise, then 6 lines of 8 href cycles each with 2-cycle gaps. Required response:
- frame_start appears once.
- win_valid is 1 exactly 24 times, covering rows 2..5 and cols 2..7.
- frame_done appears once, after the row-5 h_fall.
- err_line=0 and err_frame=0.
REQ-035 Border check in the nominal frame:
- The first win_valid has pix_x=2, pix_y=2, border_l=1 and border_t=1.
- The last has pix_x=7, pix_y=5, border_r=1 and border_b=1.
REQ-036 Short line: row 3 has 7 pixels. Required response:
- err_line=1 from the cycle after that h_fall.
- The FSM still reaches DONE after row 5.
- err_line clears on the next vs_rise.
REQ-037 Truncation: vs_rise during row 3. Required response:
- err_frame=1 and frame_start=1 in the same cycle.
- State=FILL and the counters are 0.
REQ-038 Overrun: 4 href cycles after DONE. Required response:
- line_shift_ce=0 and win_valid=0.
- err_frame=1 and state stays DONE.
REQ-039 Reset during RUN: rst high for 1 cycle. Required response:
- All outputs are 0 and state=IDLE.
- href without vs_rise gives line_shift_ce=0.
